rom_sequencer: RTL and testbench

ROM_SEQUENCER -- requirements
Module: rom_sequencer

---
 rtl/rom_sequencer.sv | 163 ++++++++++++++++
 tb/tb_rom_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_sequencer.sv
// Burst reader: walks a ROM address range (optionally looping) and hands each
// word to a consumer over a valid/ready handshake, one word per two cycles.
module rom_sequencer #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    input  logic              loop_en,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_rd,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [ADDR_W-1:0] start_q;
    logic [ADDR_W-1:0] end_q;
    logic              loop_q;

    logic [ADDR_W-1:0] start_nxt;
    logic [ADDR_W-1:0] end_nxt;
    logic              loop_nxt;
    logic [ADDR_W-1:0] rom_addr_nxt;
    logic              rom_rd_nxt;
    logic [DATA_W-1:0] dout_nxt;
    logic              dout_valid_nxt;
    logic              done_nxt;

    logic xfer;
    logic last;

    assign xfer = dout_valid && dout_ready;
    assign last = (rom_addr == end_q);
    assign busy = (state != IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; abort always wins over an in-flight handshake
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                state_nxt = abort ? IDLE : HOLD;
            end
            HOLD: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (xfer) begin
                    state_nxt = (last && !loop_q) ? IDLE : READ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Next values for the registered outputs and latched burst parameters
    always_comb begin
        start_nxt      = start_q;
        end_nxt        = end_q;
        loop_nxt       = loop_q;
        rom_addr_nxt   = rom_addr;
        rom_rd_nxt     = rom_rd;
        dout_nxt       = dout;
        dout_valid_nxt = dout_valid;
        done_nxt       = 1'b0;
        unique case (state)
            IDLE: begin
                rom_rd_nxt     = 1'b0;
                dout_valid_nxt = 1'b0;
                if (start) begin
                    start_nxt    = start_addr;
                    end_nxt      = end_addr;
                    loop_nxt     = loop_en;
                    rom_addr_nxt = start_addr;
                    rom_rd_nxt   = 1'b1;
                end
            end
            READ: begin
                rom_rd_nxt = 1'b0;
                if (abort) begin
                    dout_valid_nxt = 1'b0;
                end else begin
                    dout_nxt       = rom_data;
                    dout_valid_nxt = 1'b1;
                end
            end
            HOLD: begin
                if (abort) begin
                    rom_rd_nxt     = 1'b0;
                    dout_valid_nxt = 1'b0;
                end else if (xfer) begin
                    dout_valid_nxt = 1'b0;
                    if (!last) begin
                        rom_addr_nxt = rom_addr + ADDR_W'(1);
                        rom_rd_nxt   = 1'b1;
                    end else if (loop_q) begin
                        rom_addr_nxt = start_q;
                        rom_rd_nxt   = 1'b1;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            default: begin
                rom_rd_nxt     = 1'b0;
                dout_valid_nxt = 1'b0;
            end
        endcase
    end

    // Output and parameter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            start_q    <= '0;
            end_q      <= '0;
            loop_q     <= 1'b0;
            rom_addr   <= '0;
            rom_rd     <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            done       <= 1'b0;
        end else begin
            start_q    <= start_nxt;
            end_q      <= end_nxt;
            loop_q     <= loop_nxt;
            rom_addr   <= rom_addr_nxt;
            rom_rd     <= rom_rd_nxt;
            dout       <= dout_nxt;
            dout_valid <= dout_valid_nxt;
            done       <= done_nxt;
        end
    end

endmodule

// File: tb/tb_rom_sequencer.sv
// Bench for rom_sequencer: directed and random bursts against a word-list model
// of the burst (address range, wrap, loop) with ROM data = addr ^ 4'hA.
module tb_rom_sequencer;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [AW-1:0] start_addr;
    logic [AW-1:0] end_addr;
    logic          loop_en;
    logic [AW-1:0] rom_addr;
    logic          rom_rd;
    logic [DW-1:0] rom_data;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign rom_data = DW'(rom_addr) ^ DW'(4'hA);

    rom_sequencer #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .abort(abort),
        .start_addr(start_addr),
        .end_addr(end_addr),
        .loop_en(loop_en),
        .rom_addr(rom_addr),
        .rom_rd(rom_rd),
        .rom_data(rom_data),
        .dout(dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .busy(busy),
        .done(done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected word k of a burst: address start + (k mod length), data = addr ^ A
    function automatic logic [3:0] exp_addr(input logic [3:0] s, input int k, input int len);
        exp_addr = s + 4'(k % len);
    endfunction

    // Runs one burst; lp bursts are aborted after nwords transfers.
    task automatic burst(input logic [3:0] s, input logic [3:0] e, input bit lp,
                         input int pct, input int stall, input int nwords);
        int          len;
        int          total;
        int          idx;
        int          nvalid;
        int          cyc;
        bit          rdy;
        bit          xfer;
        bit          finished;
        bit          prev_hold;
        logic [3:0]  prev_dout;
        len       = int'(4'(e - s)) + 1;
        total     = lp ? nwords : len;
        idx       = 0;
        nvalid    = 0;
        finished  = 1'b0;
        prev_hold = 1'b0;
        prev_dout = '0;
        abort      = 1'b0;
        dout_ready = 1'b0;
        start_addr = s;
        end_addr   = e;
        loop_en    = lp;
        start      = 1'b1;
        tick();
        start = 1'b0;
        chk("first_rd", 32'(rom_rd), 32'(1));
        chk("first_addr", 32'(rom_addr), 32'(s));
        chk("first_busy", 32'(busy), 32'(1));
        chk("first_valid_early", 32'(dout_valid), 32'(0));
        tick();
        chk("latency_valid", 32'(dout_valid), 32'(1));
        for (cyc = 0; cyc < 400; cyc++) begin
            chk("busy_mid", 32'(busy), 32'(1));
            chk("done_mid", 32'(done), 32'(0));
            chk("rd_vs_valid", 32'(rom_rd), 32'(!dout_valid));
            if (prev_hold) begin
                chk("hold_valid", 32'(dout_valid), 32'(1));
                chk("hold_dout", 32'(dout), 32'(prev_dout));
            end
            if (dout_valid) begin
                nvalid++;
                chk("dout", 32'(dout), 32'(exp_addr(s, idx, len) ^ 4'hA));
            end else begin
                chk("rom_addr", 32'(rom_addr), 32'(exp_addr(s, idx, len)));
            end
            rdy        = (nvalid > stall) && (int'($urandom_range(99)) < pct);
            dout_ready = rdy;
            start      = ($urandom_range(3) == 0);
            start_addr = 4'($urandom);
            end_addr   = 4'($urandom);
            loop_en    = 1'($urandom);
            xfer       = dout_valid && rdy;
            prev_hold  = dout_valid && !rdy;
            prev_dout  = dout;
            tick();
            if (xfer) begin
                idx++;
                if (idx == total) begin
                    finished = 1'b1;
                    break;
                end
            end
        end
        start      = 1'b0;
        dout_ready = 1'b0;
        if (!finished) begin
            chk("burst_timeout", 32'(0), 32'(1));
            abort = 1'b1;
            tick();
            abort = 1'b0;
            return;
        end
        if (pct == 100 && stall == 0) begin
            chk("throughput", 32'(cyc + 1), 32'(2 * total - 1));
        end
        if (!lp) begin
            chk("done_pulse", 32'(done), 32'(1));
            chk("end_busy", 32'(busy), 32'(0));
            chk("end_valid", 32'(dout_valid), 32'(0));
            chk("end_rd", 32'(rom_rd), 32'(0));
            tick();
            chk("done_clear", 32'(done), 32'(0));
        end else begin
            chk("loop_busy", 32'(busy), 32'(1));
            abort = 1'b1;
            tick();
            abort = 1'b0;
            chk("abort_busy", 32'(busy), 32'(0));
            chk("abort_valid", 32'(dout_valid), 32'(0));
            chk("abort_rd", 32'(rom_rd), 32'(0));
            chk("abort_done", 32'(done), 32'(0));
            tick();
            chk("abort_done2", 32'(done), 32'(0));
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b1;
        abort      = 1'b0;
        start_addr = 4'h7;
        end_addr   = 4'h9;
        loop_en    = 1'b1;
        dout_ready = 1'b1;
        tick();
        tick();
        chk("rst_addr", 32'(rom_addr), 32'(0));
        chk("rst_rd", 32'(rom_rd), 32'(0));
        chk("rst_dout", 32'(dout), 32'(0));
        chk("rst_valid", 32'(dout_valid), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        start = 1'b0;
        rst   = 1'b0;
        tick();
        chk("idle_busy", 32'(busy), 32'(0));

        burst(4'h2, 4'h5, 1'b0, 100, 0, 0);
        burst(4'hE, 4'h1, 1'b0, 100, 0, 0);
        burst(4'h3, 4'h3, 1'b0, 100, 5, 0);
        burst(4'h0, 4'h1, 1'b1, 100, 0, 8);

        // abort beats a simultaneous ready in HOLD
        start_addr = 4'h0;
        end_addr   = 4'h7;
        loop_en    = 1'b0;
        start      = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("ab_hold_valid", 32'(dout_valid), 32'(1));
        dout_ready = 1'b1;
        abort      = 1'b1;
        tick();
        abort      = 1'b0;
        dout_ready = 1'b0;
        chk("ab_win_busy", 32'(busy), 32'(0));
        chk("ab_win_valid", 32'(dout_valid), 32'(0));
        chk("ab_win_done", 32'(done), 32'(0));
        tick();
        chk("ab_win_done2", 32'(done), 32'(0));

        // start and abort together in IDLE: start honoured
        start_addr = 4'h9;
        end_addr   = 4'hB;
        start      = 1'b1;
        abort      = 1'b1;
        tick();
        start = 1'b0;
        chk("st_ab_busy", 32'(busy), 32'(1));
        chk("st_ab_rd", 32'(rom_rd), 32'(1));
        chk("st_ab_addr", 32'(rom_addr), 32'(9));
        tick();
        abort = 1'b0;
        chk("st_ab_cleanup", 32'(busy), 32'(0));

        // reset during HOLD discards the word
        start_addr = 4'h5;
        end_addr   = 4'h8;
        start      = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("rh_valid", 32'(dout_valid), 32'(1));
        rst        = 1'b1;
        dout_ready = 1'b1;
        tick();
        rst        = 1'b0;
        dout_ready = 1'b0;
        chk("rh_addr", 32'(rom_addr), 32'(0));
        chk("rh_rd", 32'(rom_rd), 32'(0));
        chk("rh_dout", 32'(dout), 32'(0));
        chk("rh_valid0", 32'(dout_valid), 32'(0));
        chk("rh_done", 32'(done), 32'(0));
        chk("rh_busy", 32'(busy), 32'(0));
        tick();
        chk("rh_done2", 32'(done), 32'(0));

        for (int n = 0; n < 20; n++) begin
            burst(4'($urandom), 4'($urandom), 1'($urandom),
                  int'($urandom_range(30, 100)), int'($urandom_range(0, 2)),
                  int'($urandom_range(1, 10)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
